// File: rtl/prv_trap_ctrl_if.sv
// rtl/prv_trap_ctrl_if.sv - pipeline/CSR bundle for the machine-mode trap sequencer
interface prv_trap_ctrl_if;
    logic        exc_fetch_mis;
    logic        exc_illegal;
    logic        exc_break;
    logic        exc_load_mis;
    logic        exc_store_mis;
    logic        exc_ecall;
    logic        exc_valid;
    logic [31:0] epc;
    logic [31:0] badaddr;
    logic        mret_req;
    logic        ext_int;
    logic        soft_int;
    logic        timer_int;
    logic        pc_ack;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mie;
    logic [31:0] mip;
    logic [31:0] mstatus;
    logic [31:0] mcause;

    logic        mip_rup;
    logic        mbadaddr_rup;
    logic        mcause_rup;
    logic        mepc_rup;
    logic        mstatus_rup;
    logic [31:0] mip_next;
    logic [31:0] mbadaddr_next;
    logic [31:0] mcause_next;
    logic [31:0] mepc_next;
    logic [31:0] mstatus_next;
    logic        busy;
    logic        insert_pc;
    logic [31:0] priv_pc;

    modport master (
        output exc_fetch_mis, exc_illegal, exc_break, exc_load_mis, exc_store_mis, exc_ecall,
        output exc_valid, epc, badaddr, mret_req, ext_int, soft_int, timer_int, pc_ack,
        output mtvec, mepc, mie, mip, mstatus, mcause,
        input  mip_rup, mbadaddr_rup, mcause_rup, mepc_rup, mstatus_rup,
        input  mip_next, mbadaddr_next, mcause_next, mepc_next, mstatus_next,
        input  busy, insert_pc, priv_pc
    );

    modport slave (
        input  exc_fetch_mis, exc_illegal, exc_break, exc_load_mis, exc_store_mis, exc_ecall,
        input  exc_valid, epc, badaddr, mret_req, ext_int, soft_int, timer_int, pc_ack,
        input  mtvec, mepc, mie, mip, mstatus, mcause,
        output mip_rup, mbadaddr_rup, mcause_rup, mepc_rup, mstatus_rup,
        output mip_next, mbadaddr_next, mcause_next, mepc_next, mstatus_next,
        output busy, insert_pc, priv_pc
    );
endinterface

// File: rtl/prv_trap_ctrl.sv
// rtl/prv_trap_ctrl.sv - machine-mode trap/MRET sequencer driving CSR update strobes and fetch redirect
// Optional: PRV_VECTORED_INT_EN enables vectored interrupt targets when mtvec[1:0]==2'b01.
module prv_trap_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input  logic          CLK,
    input  logic          RST,
    prv_trap_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVE,
        ST_RESTORE,
        ST_REDIRECT
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        int_q;
    logic        mret_q;
    logic [3:0]  code_q;
    logic [29:0] epc_q;
    logic [31:0] badaddr_q;

    logic [31:0] mip_nxt;
    logic        int_ext;
    logic        int_soft;
    logic        int_timer;
    logic        int_pending;
    logic        exc_any;
    logic [3:0]  exc_code;
    logic [3:0]  int_code;
    logic        take_trap;
    logic        take_mret;
    logic [31:0] trap_target;
    logic        unused_bits;

    assign unused_bits = ^{bus.mcause, bus.epc[1:0], bus.mepc[1:0], bus.mtvec[1:0], bus.mie};

    // Interrupt lines overwrite their mip bits; pending is judged on the updated view.
    always_comb begin
        mip_nxt     = bus.mip;
        mip_nxt[11] = bus.ext_int;
        mip_nxt[7]  = bus.timer_int;
        mip_nxt[3]  = bus.soft_int;
    end

    assign int_ext     = bus.mie[11] & mip_nxt[11];
    assign int_soft    = bus.mie[3]  & mip_nxt[3];
    assign int_timer   = bus.mie[7]  & mip_nxt[7];
    assign int_pending = bus.mstatus[3] & (int_ext | int_soft | int_timer);

    assign exc_any = bus.exc_valid & (bus.exc_fetch_mis | bus.exc_illegal | bus.exc_break |
                                      bus.exc_load_mis | bus.exc_store_mis | bus.exc_ecall);

    always_comb begin
        exc_code = 4'd0;
        if (bus.exc_fetch_mis)      exc_code = 4'd0;
        else if (bus.exc_illegal)   exc_code = 4'd2;
        else if (bus.exc_break)     exc_code = 4'd3;
        else if (bus.exc_load_mis)  exc_code = 4'd4;
        else if (bus.exc_store_mis) exc_code = 4'd6;
        else if (bus.exc_ecall)     exc_code = 4'd11;
    end

    always_comb begin
        int_code = 4'd7;
        if (int_ext)       int_code = 4'd11;
        else if (int_soft) int_code = 4'd3;
    end

    assign take_trap = (state_q == ST_IDLE) & (exc_any | int_pending);
    assign take_mret = (state_q == ST_IDLE) & ~(exc_any | int_pending) & bus.mret_req;

    always_comb begin
        trap_target = {bus.mtvec[31:2], 2'b00};
`ifdef PRV_VECTORED_INT_EN
        if (int_q && (bus.mtvec[1:0] == 2'b01))
            trap_target = {bus.mtvec[31:2], 2'b00} + {26'd0, code_q, 2'b00};
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            int_q     <= 1'b0;
            mret_q    <= 1'b0;
            code_q    <= 4'd0;
            epc_q     <= 30'd0;
            badaddr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (take_trap) begin
                int_q     <= ~exc_any;
                mret_q    <= 1'b0;
                code_q    <= exc_any ? exc_code : int_code;
                epc_q     <= bus.epc[31:2];
                badaddr_q <= bus.badaddr;
            end else if (take_mret) begin
                mret_q <= 1'b1;
            end
        end
    end

    // Outputs are forced quiet while RST is high so a reset mid-sequence drops every strobe at once.
    always_comb begin
        state_d           = state_q;
        bus.mip_rup       = 1'b0;
        bus.mip_next      = 32'd0;
        bus.mbadaddr_rup  = 1'b0;
        bus.mbadaddr_next = 32'd0;
        bus.mcause_rup    = 1'b0;
        bus.mcause_next   = 32'd0;
        bus.mepc_rup      = 1'b0;
        bus.mepc_next     = 32'd0;
        bus.mstatus_rup   = 1'b0;
        bus.mstatus_next  = 32'd0;
        bus.busy          = 1'b0;
        bus.insert_pc     = 1'b0;
        bus.priv_pc       = RESET_PC;
        if (!RST) begin
            bus.mip_next = mip_nxt;
            bus.mip_rup  = (mip_nxt != bus.mip);
            case (state_q)
                ST_IDLE: begin
                    if (take_trap) begin
                        state_d  = ST_SAVE;
                        bus.busy = 1'b1;
                    end else if (take_mret) begin
                        state_d  = ST_RESTORE;
                        bus.busy = 1'b1;
                    end
                end
                ST_SAVE: begin
                    bus.busy           = 1'b1;
                    bus.mepc_rup       = 1'b1;
                    bus.mepc_next      = {epc_q, 2'b00};
                    bus.mcause_rup     = 1'b1;
                    bus.mcause_next    = {int_q, 27'd0, code_q};
                    bus.mstatus_rup    = 1'b1;
                    bus.mstatus_next   = bus.mstatus;
                    bus.mstatus_next[7] = bus.mstatus[3];
                    bus.mstatus_next[3] = 1'b0;
                    if (!int_q && (code_q == 4'd0 || code_q == 4'd4 || code_q == 4'd6)) begin
                        bus.mbadaddr_rup  = 1'b1;
                        bus.mbadaddr_next = badaddr_q;
                    end
                    state_d = ST_REDIRECT;
                end
                ST_RESTORE: begin
                    bus.busy            = 1'b1;
                    bus.mstatus_rup     = 1'b1;
                    bus.mstatus_next    = bus.mstatus;
                    bus.mstatus_next[3] = bus.mstatus[7];
                    bus.mstatus_next[7] = 1'b1;
                    state_d             = ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    bus.busy      = 1'b1;
                    bus.insert_pc = 1'b1;
                    bus.priv_pc   = mret_q ? {bus.mepc[31:2], 2'b00} : trap_target;
                    if (bus.pc_ack)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/prv_trap_ctrl.md
Name: prv_trap_ctrl

Overview:
- Machine-mode trap sequencer; sits directly upstream of the CSR regfile on the csr/prv interface.
- Takes exception flags, interrupt lines and MRET requests from the pipeline, drives the *_rup/*_next CSR update strobes, and redirects the fetch PC to mtvec or mepc.
- Consumes mtvec, mepc, mie, mip and mstatus from the CSR regfile.

Parameters:
- RESET_PC, 32'h0000_0200, value reported on priv_pc while idle/reset (informational only; insert_pc=0).

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- exc_fetch_mis, exc_illegal, exc_break, exc_load_mis, exc_store_mis, exc_ecall  in  1 each  exception flags, qualified by exc_valid
- exc_valid  in  1  exception flags and epc/badaddr are valid this cycle
- epc  in  32  PC of the faulting/interrupted instruction
- badaddr  in  32  faulting address for misaligned exceptions
- mret_req  in  1  MRET retiring
- ext_int, soft_int, timer_int  in  1 each  raw interrupt lines (level)
- pc_ack  in  1  fetch has accepted the redirect
- mtvec, mepc, mie, mip, mstatus, mcause  in  32 each  current CSR values
- mip_rup, mbadaddr_rup, mcause_rup, mepc_rup, mstatus_rup  out  1 each  CSR write strobes
- mip_next, mbadaddr_next, mcause_next, mepc_next, mstatus_next  out  32 each  CSR write data
- busy  out  1  pipeline must stall; no new exc/mret accepted
- insert_pc  out  1  redirect valid
- priv_pc  out  32  redirect target

Behaviour:
- Reset (async, RST=1): state IDLE; all *_rup=0, busy=0, insert_pc=0, all *_next=0, priv_pc=RESET_PC. Reset mid-sequence aborts it; no partial CSR write survives past reset.
- mip path, every cycle regardless of state:
  - mip_next = mip with bit11=ext_int, bit7=timer_int, bit3=soft_int.
  - mip_rup=1 only when mip_next != mip.
- Interrupt pending = mstatus[3] (MIE) & (mie & mip_next) nonzero on bits 11/3/7.
- Priority:
  - Exceptions beat interrupts; interrupts beat mret_req.
  - Exception order, highest first, with mcause code: fetch_mis (0), illegal (2), break (3), load_mis (4), store_mis (6), ecall (11).
  - Interrupt order: ext (11), soft (3), timer (7). mcause[31]=1 for interrupts, 0 for exceptions.
- Trap acceptance (IDLE only):
  - Exception accepted when exc_valid=1.
  - Interrupt accepted when pending and no exception; captured epc is used as resume PC.
  - The taken cause, epc and badaddr are registered at acceptance; inputs are ignored while busy.
- FSM:
  - IDLE:
    - exception/interrupt -> SAVE
    - else mret_req -> RESTORE
    - else stay
  - SAVE (1 cycle):
    - mepc_rup=mcause_rup=mstatus_rup=1; mepc_next={epc[31:2],2'b00}; mcause_next=cause.
    - mstatus_next = mstatus with bit7 (MPIE) = old bit3 and bit3=0.
    - mbadaddr_rup=1 with mbadaddr_next=badaddr only for codes 0, 4, 6 (exceptions).
    - -> REDIRECT.
  - RESTORE (1 cycle):
    - mstatus_rup=1; mstatus_next = mstatus with bit3 = old bit7 and bit7=1.
    - -> REDIRECT.
  - REDIRECT:
    - insert_pc=1.
    - priv_pc = {mtvec[31:2],2'b00} for traps, {mepc[31:2],2'b00} for mret.
    - Stay until pc_ack=1, then IDLE. pc_ack in the same cycle insert_pc first rises completes the redirect.
- busy=1 in SAVE, RESTORE and REDIRECT, and combinationally in IDLE during the accept cycle.
- All *_rup strobes are single-cycle pulses, except mip_rup.
- Simultaneous exc_valid and mret_req: exception taken, mret dropped; the pipeline reissues it.
- Latency:
  - Trap: accept cycle +1 (SAVE) +1 -> insert_pc asserted 2 cycles after acceptance.
  - MRET: same.
- Interrupt pending during REDIRECT of an mret: sampled again after return to IDLE, so MIE restore takes effect first.

Optional Feature:
- PRV_VECTORED_INT_EN defined:
  - For interrupts with mtvec[1:0]==2'b01, priv_pc = {mtvec[31:2],2'b00} + (cause_code<<2).
  - Exceptions always use the base.
- Not defined: mtvec[1:0] ignored; all traps go to the base.

Test Plan:
- exc_valid+exc_illegal, epc=0x104, mtvec=0x800, mstatus=0x8 -> SAVE: mepc_next=0x104, mcause_next=2, mstatus_next=0x80, mbadaddr_rup=0; next cycle insert_pc=1, priv_pc=0x800; pc_ack -> busy=0.
- exc_valid with exc_load_mis+exc_ecall, badaddr=0x2003 -> mcause_next=4, mbadaddr_rup=1, mbadaddr_next=0x2003.
- timer_int=1, mie=0x80, mstatus=0x8 -> mip_rup with mip_next bit7=1; trap with mcause_next=0x8000_0007. Repeat with mstatus=0 -> no trap.
- mret_req, mstatus=0x80, mepc=0x300 -> mstatus_next=0x88; priv_pc=0x300. Same cycle exc_break -> cause 3 taken, mret ignored.
- With PRV_VECTORED_INT_EN: ext_int trap, mtvec=0x801 -> priv_pc=0x82C. Without the macro -> 0x800.
- Assert RST during REDIRECT -> insert_pc, busy and all *_rup=0 immediately; FSM in IDLE after RST drops.
